// File: rtl/lfsr_checker.sv
// PRBS checker for an 8-bit Fibonacci LFSR with a programmable tap mask.
// It seeds itself from the first 8 received bits, then free-runs and counts mismatches.
module lfsr_checker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  taps,
  input  logic        data_in,
  input  logic        data_valid,
  output logic        busy,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [15:0] bit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  lfsr_r, lfsr_s;
  logic [7:0]  taps_r, taps_s;
  logic [2:0]  seed_cnt_r, seed_cnt_s;
  logic [2:0]  cerr_r, cerr_s;
  logic [7:0]  err_count_r, err_count_s;
  logic [15:0] bit_count_r, bit_count_s;
  logic        err_pulse_r, err_pulse_s;
  logic        busy_r, locked_r;
  logic        start_ok_s;
  logic        exp_bit_s;

  // Feedback bit: parity of the tapped state bits.
  function automatic logic fb_bit(input logic [7:0] st, input logic [7:0] tp);
    return ^(st & tp);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v != 8'hFF) begin
      return v + 8'd1;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v != 16'hFFFF) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

  // Next-state and next-counter logic; stop beats start, start beats data.
  always_comb begin
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    taps_s      = taps_r;
    seed_cnt_s  = seed_cnt_r;
    cerr_s      = cerr_r;
    err_count_s = err_count_r;
    bit_count_s = bit_count_r;
    err_pulse_s = 1'b0;
    start_ok_s  = start & (taps != 8'h00) & ~stop;
    exp_bit_s   = fb_bit(lfsr_r, taps_r);

    if (stop && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else if (start_ok_s) begin
      state_s     = ST_SEED;
      taps_s      = taps;
      seed_cnt_s  = 3'd0;
      cerr_s      = 3'd0;
      err_count_s = 8'h00;
      bit_count_s = 16'h0000;
    end else if (data_valid) begin
      case (state_r)
        ST_SEED: begin
          lfsr_s = {lfsr_r[6:0], data_in};
          if (seed_cnt_r == 3'd7) begin
            // An all-zero seed would lock the LFSR, so keep seeding instead.
            seed_cnt_s = 3'd0;
            if (lfsr_s != 8'h00) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_SEED;
            end
          end else begin
            seed_cnt_s = seed_cnt_r + 3'd1;
          end
        end
        ST_CHECK: begin
          // Shift the expected bit so a received error cannot corrupt the state.
          lfsr_s      = {lfsr_r[6:0], exp_bit_s};
          bit_count_s = sat_inc16(bit_count_r);
          if (data_in != exp_bit_s) begin
            err_pulse_s = 1'b1;
            err_count_s = sat_inc8(err_count_r);
            if (cerr_r == 3'd3) begin
              state_s    = ST_SEED;
              seed_cnt_s = 3'd0;
              cerr_s     = 3'd0;
            end else begin
              cerr_s = cerr_r + 3'd1;
            end
          end else begin
            cerr_s = 3'd0;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= 8'h00;
      taps_r      <= 8'h00;
      seed_cnt_r  <= 3'd0;
      cerr_r      <= 3'd0;
      err_count_r <= 8'h00;
      bit_count_r <= 16'h0000;
      err_pulse_r <= 1'b0;
      busy_r      <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      taps_r      <= taps_s;
      seed_cnt_r  <= seed_cnt_s;
      cerr_r      <= cerr_s;
      err_count_r <= err_count_s;
      bit_count_r <= bit_count_s;
      err_pulse_r <= err_pulse_s;
      busy_r      <= (state_s != ST_IDLE);
      locked_r    <= (state_s == ST_CHECK);
    end
  end

  assign busy      = busy_r;
  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;
  assign bit_count = bit_count_r;

endmodule
